// File: rtl/tlu_rx_pkg.sv
// Shared types and helpers for the multi-channel TLU receiver.
// Holds the per-channel state encoding and saturating arithmetic.
package tlu_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        DEAD = 2'd2
    } rx_state_t;

    localparam int TOT_MAX    = 255;
    localparam int MISSED_MAX = 255;

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] lim);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[31:0];
    endfunction

endpackage

// File: rtl/tlu_edge_finder.sv
// Locates rising/falling sample edges in one extended word (MSB-side sample is earliest).
// Purely combinational; x[SAMPLES] is the last sample of the previous word.
module tlu_edge_finder #(
    parameter int SAMPLES = 16,
    parameter int POS_W   = $clog2(SAMPLES)
) (
    input  logic [SAMPLES:0]   x,
    output logic               rise_found,
    output logic [POS_W-1:0]   rpos,
    output logic               fall_found,
    output logic               fall_after_rise,
    output logic [POS_W-1:0]   fpos_after_rise,
    output logic [POS_W-1:0]   fpos_first,
    output logic [POS_W-1:0]   extra_rise_cnt
);

    logic [SAMPLES-1:0] rise_vec;
    logic [SAMPLES-1:0] fall_vec;

    assign rise_vec = x[SAMPLES-1:0] & ~x[SAMPLES:1];
    assign fall_vec = ~x[SAMPLES-1:0] & x[SAMPLES:1];

    // Walk from the earliest sample (highest bit) to the latest.
    always_comb begin
        rise_found      = 1'b0;
        rpos            = '0;
        fall_found      = 1'b0;
        fall_after_rise = 1'b0;
        fpos_after_rise = '0;
        fpos_first      = '0;
        extra_rise_cnt  = '0;
        for (int i = SAMPLES - 1; i >= 0; i--) begin
            if (rise_vec[i]) begin
                if (!rise_found) begin
                    rise_found = 1'b1;
                    rpos       = POS_W'(SAMPLES - 1 - i);
                end else begin
                    extra_rise_cnt = extra_rise_cnt + POS_W'(1);
                end
            end
            if (fall_vec[i]) begin
                if (!fall_found) begin
                    fall_found = 1'b1;
                    fpos_first = POS_W'(SAMPLES - 1 - i);
                end
                if (rise_found && !fall_after_rise) begin
                    fall_after_rise = 1'b1;
                    fpos_after_rise = POS_W'(SAMPLES - 1 - i);
                end
            end
        end
    end

endmodule

// File: rtl/tlu_multi_ch_rx.sv
// Per-channel pulse edge/TOT measurement with threshold, dead time and missed-pulse count.
// Report registered one cycle after the trailing-edge word; no backpressure, input every cycle.
module tlu_multi_ch_rx
    import tlu_rx_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int SAMPLES = 16,
    parameter int POS_W   = $clog2(SAMPLES),
    parameter int TS_W    = 4,
    parameter int TOT_W   = $clog2(TOT_MAX + 1),
    parameter int DEAD_W  = 4
) (
    input  logic                          CLK40,
    input  logic                          RST_N,
    input  logic [TS_W-1:0]               TIME_STAMP,
    input  logic [NCH*SAMPLES-1:0]        DATA,
    input  logic [NCH-1:0]                EN,
    input  logic [NCH-1:0]                EN_INVERT,
    input  logic [TOT_W-1:0]              DIG_TH,
    input  logic [DEAD_W-1:0]             DEAD_CYC,
    input  logic                          CLR_CNT,
    output logic [NCH-1:0]                VALID,
    output logic [NCH*(TS_W+POS_W)-1:0]   LE_TIME,
    output logic [NCH*TOT_W-1:0]          TOT,
    output logic [NCH-1:0]                BUSY,
    output logic [NCH*8-1:0]              MISSED
);

    localparam int          LE_W    = TS_W + POS_W;
    localparam logic [31:0] TOT_SAT = 32'((1 << TOT_W) - 1);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [SAMPLES-1:0] w;
        logic               prev_lsb_q;
        logic               rise_found, fall_found, fall_after_rise;
        logic [POS_W-1:0]   rpos, fpos_after_rise, fpos_first, extra_rise_cnt;

        rx_state_t          state_q, state_d;
        logic [TOT_W-1:0]   acc_q, acc_d;
        logic [LE_W-1:0]    lead_q, lead_d;
        logic [DEAD_W-1:0]  dead_q, dead_d;

        logic               rep;
        logic [TOT_W-1:0]   rep_tot;
        logic [LE_W-1:0]    rep_le;
        logic [POS_W-1:0]   miss_inc;

        logic               valid_q;
        logic [LE_W-1:0]    le_q;
        logic [TOT_W-1:0]   tot_q;
        logic [7:0]         missed_q;

        assign w = DATA[c*SAMPLES +: SAMPLES] ^ {SAMPLES{EN_INVERT[c]}};

        tlu_edge_finder #(
            .SAMPLES (SAMPLES),
            .POS_W   (POS_W)
        ) u_edge (
            .x               ({prev_lsb_q, w}),
            .rise_found      (rise_found),
            .rpos            (rpos),
            .fall_found      (fall_found),
            .fall_after_rise (fall_after_rise),
            .fpos_after_rise (fpos_after_rise),
            .fpos_first      (fpos_first),
            .extra_rise_cnt  (extra_rise_cnt)
        );

        always_comb begin
            state_d  = state_q;
            acc_d    = acc_q;
            lead_d   = lead_q;
            dead_d   = dead_q;
            rep      = 1'b0;
            rep_tot  = '0;
            rep_le   = lead_q;
            miss_inc = '0;
            unique case (state_q)
                IDLE: begin
                    if (rise_found) begin
                        if (fall_after_rise) begin
                            rep      = 1'b1;
                            rep_tot  = TOT_W'(fpos_after_rise - rpos);
                            rep_le   = {TIME_STAMP, rpos};
                            miss_inc = extra_rise_cnt;
                        end else begin
                            acc_d   = TOT_W'(SAMPLES) - TOT_W'(rpos);
                            lead_d  = {TIME_STAMP, rpos};
                            state_d = HIGH;
                        end
                    end
                end
                HIGH: begin
                    // Word starts high, so every rising edge here follows the terminating fall.
                    if (fall_found) begin
                        rep      = 1'b1;
                        rep_tot  = TOT_W'(sat_add(32'(acc_q), 32'(fpos_first), TOT_SAT));
                        miss_inc = extra_rise_cnt + POS_W'(rise_found);
                    end else begin
                        acc_d = TOT_W'(sat_add(32'(acc_q), 32'(SAMPLES), TOT_SAT));
                    end
                end
                DEAD: begin
                    if (dead_q == '0) state_d = IDLE;
                    else              dead_d  = dead_q - DEAD_W'(1);
                end
                default: state_d = IDLE;
            endcase
            if (rep) begin
                if (DEAD_CYC != '0) begin
                    state_d = DEAD;
                    dead_d  = DEAD_CYC - DEAD_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            if (!EN[c]) begin
                state_d  = IDLE;
                rep      = 1'b0;
                miss_inc = '0;
            end
        end

        always_ff @(posedge CLK40 or negedge RST_N) begin
            if (!RST_N) begin
                state_q    <= IDLE;
                acc_q      <= '0;
                lead_q     <= '0;
                dead_q     <= '0;
                prev_lsb_q <= 1'b0;
                valid_q    <= 1'b0;
                le_q       <= '0;
                tot_q      <= '0;
                missed_q   <= '0;
            end else begin
                state_q    <= state_d;
                acc_q      <= acc_d;
                lead_q     <= lead_d;
                dead_q     <= dead_d;
                prev_lsb_q <= w[0];
                valid_q    <= rep && (rep_tot > DIG_TH);
                if (rep) begin
                    le_q  <= rep_le;
                    tot_q <= rep_tot;
                end
                if (CLR_CNT)
                    missed_q <= '0;
                else if (miss_inc != '0)
                    missed_q <= 8'(sat_add(32'(missed_q), 32'(miss_inc), 32'(MISSED_MAX)));
            end
        end

        assign VALID[c]                 = valid_q;
        assign BUSY[c]                  = (state_q != IDLE);
        assign LE_TIME[c*LE_W +: LE_W]  = le_q;
        assign TOT[c*TOT_W +: TOT_W]    = tot_q;
        assign MISSED[c*8 +: 8]         = missed_q;
    end

endmodule

// File: tb/tb_tlu_multi_ch_rx.sv
// Bench for tlu_multi_ch_rx: directed cases plus random words against a sample-walking reference model.
module tb_tlu_multi_ch_rx;

    localparam int NCH     = 4;
    localparam int SAMPLES = 16;
    localparam int POS_W   = 4;
    localparam int TS_W    = 4;
    localparam int TOT_W   = 8;
    localparam int DEAD_W  = 4;
    localparam int LE_W    = TS_W + POS_W;

    logic                        CLK40 = 1'b0;
    logic                        RST_N;
    logic [TS_W-1:0]             TIME_STAMP;
    logic [NCH*SAMPLES-1:0]      DATA;
    logic [NCH-1:0]              EN;
    logic [NCH-1:0]              EN_INVERT;
    logic [TOT_W-1:0]            DIG_TH;
    logic [DEAD_W-1:0]           DEAD_CYC;
    logic                        CLR_CNT;
    logic [NCH-1:0]              VALID;
    logic [NCH*LE_W-1:0]         LE_TIME;
    logic [NCH*TOT_W-1:0]        TOT;
    logic [NCH-1:0]              BUSY;
    logic [NCH*8-1:0]            MISSED;

    tlu_multi_ch_rx #(
        .NCH (NCH), .SAMPLES (SAMPLES), .POS_W (POS_W),
        .TS_W (TS_W), .TOT_W (TOT_W), .DEAD_W (DEAD_W)
    ) dut (
        .CLK40 (CLK40), .RST_N (RST_N), .TIME_STAMP (TIME_STAMP), .DATA (DATA),
        .EN (EN), .EN_INVERT (EN_INVERT), .DIG_TH (DIG_TH), .DEAD_CYC (DEAD_CYC),
        .CLR_CNT (CLR_CNT), .VALID (VALID), .LE_TIME (LE_TIME), .TOT (TOT),
        .BUSY (BUSY), .MISSED (MISSED)
    );

    always #5 CLK40 = ~CLK40;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: pulse tracked as a run of high samples, dead time as words left to skip.
    bit              m_in   [NCH];
    int              m_cnt  [NCH];
    int              m_dead [NCH];
    bit              m_prev [NCH];
    logic [LE_W-1:0] m_lead [NCH];
    bit              e_valid  [NCH];
    logic [LE_W-1:0] e_le     [NCH];
    int              e_tot    [NCH];
    int              e_missed [NCH];
    logic [SAMPLES-1:0] last_w [NCH];

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_in[c] = 0; m_cnt[c] = 0; m_dead[c] = 0; m_prev[c] = 0; m_lead[c] = '0;
            e_valid[c] = 0; e_le[c] = '0; e_tot[c] = 0; e_missed[c] = 0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            logic [SAMPLES-1:0] w;
            bit done, pv, s;
            int extra;
            w = DATA[c*SAMPLES +: SAMPLES] ^ {SAMPLES{EN_INVERT[c]}};
            e_valid[c] = 0;
            done  = 0;
            extra = 0;
            if (!EN[c]) begin
                m_in[c]   = 0;
                m_dead[c] = 0;
            end else if (m_dead[c] > 0) begin
                m_dead[c]--;
            end else begin
                pv = m_prev[c];
                for (int p = 0; p < SAMPLES; p++) begin
                    s = w[SAMPLES-1-p];
                    if (done) begin
                        if (s && !pv) extra++;
                    end else if (m_in[c]) begin
                        if (s) m_cnt[c]++;
                        else begin done = 1; m_in[c] = 0; end
                    end else if (s && !pv) begin
                        m_in[c]   = 1;
                        m_cnt[c]  = 1;
                        m_lead[c] = {TIME_STAMP, POS_W'(p)};
                    end
                    pv = s;
                end
                if (done) begin
                    e_tot[c]    = (m_cnt[c] > 255) ? 255 : m_cnt[c];
                    e_le[c]     = m_lead[c];
                    e_valid[c]  = (e_tot[c] > int'(DIG_TH));
                    e_missed[c] = (e_missed[c] + extra > 255) ? 255 : e_missed[c] + extra;
                    m_dead[c]   = int'(DEAD_CYC);
                end
            end
            if (CLR_CNT) e_missed[c] = 0;
            m_prev[c] = w[0];
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("valid[%0d]", c),  64'(VALID[c]), 64'(e_valid[c]));
            chk($sformatf("le[%0d]", c),     64'(LE_TIME[c*LE_W +: LE_W]), 64'(e_le[c]));
            chk($sformatf("tot[%0d]", c),    64'(TOT[c*TOT_W +: TOT_W]), 64'(e_tot[c]));
            chk($sformatf("busy[%0d]", c),   64'(BUSY[c]), 64'(m_in[c] || (m_dead[c] > 0)));
            chk($sformatf("missed[%0d]", c), 64'(MISSED[c*8 +: 8]), 64'(e_missed[c]));
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK40);
        #1;
        compare_all();
        TIME_STAMP = TIME_STAMP + 1'b1;
    endtask

    task automatic set_ch0(input logic [SAMPLES-1:0] v);
        DATA[SAMPLES-1:0] = v;
    endtask

    function automatic logic [SAMPLES-1:0] gen_word(input logic [SAMPLES-1:0] last);
        int a, len;
        case ($urandom_range(0, 6))
            0, 1: return '0;
            2:    return '1;
            3:    return SAMPLES'($urandom);
            4: begin
                a   = $urandom_range(0, SAMPLES - 1);
                len = $urandom_range(1, SAMPLES - a);
                return SAMPLES'(((1 << len) - 1) << (SAMPLES - a - len));
            end
            5:       return last;
            default: return SAMPLES'(32'h0F0F << $urandom_range(0, 3));
        endcase
    endfunction

    initial begin
        RST_N = 1'b0; TIME_STAMP = '0; DATA = '0; EN = '1; EN_INVERT = '0;
        DIG_TH = 8'd5; DEAD_CYC = '0; CLR_CNT = 1'b0;
        for (int c = 0; c < NCH; c++) last_w[c] = '0;
        model_reset();
        #3;
        chk("rst_valid", 64'(VALID), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_tot", 64'(TOT), 64'd0);
        chk("rst_le", 64'(LE_TIME), 64'd0);
        chk("rst_missed", 64'(MISSED), 64'd0);
        @(posedge CLK40);
        #1;
        RST_N = 1'b1;
        tick(); tick();

        // Single in-word pulse
        TIME_STAMP = 4'd3; set_ch0(16'h0FF0); tick();
        chk("t1_valid", 64'(VALID[0]), 64'd1);
        chk("t1_tot", 64'(TOT[7:0]), 64'd8);
        chk("t1_le", 64'(LE_TIME[7:0]), 64'h34);
        set_ch0(16'h0000); tick();
        chk("t1_valid_once", 64'(VALID[0]), 64'd0);

        // Pulse spanning three words
        set_ch0(16'h00FF); tick();
        chk("t2_busy_a", 64'(BUSY[0]), 64'd1);
        set_ch0(16'hFFFF); tick();
        chk("t2_busy_b", 64'(BUSY[0]), 64'd1);
        chk("t2_novalid", 64'(VALID[0]), 64'd0);
        set_ch0(16'hF000); tick();
        chk("t2_valid", 64'(VALID[0]), 64'd1);
        chk("t2_tot", 64'(TOT[7:0]), 64'd28);
        set_ch0(16'h0000); tick();
        chk("t2_valid_once", 64'(VALID[0]), 64'd0);

        // Threshold is strict
        DIG_TH = 8'd4; set_ch0(16'h0F00); tick();
        chk("t3_valid_eq", 64'(VALID[0]), 64'd0);
        chk("t3_tot_eq", 64'(TOT[7:0]), 64'd4);
        set_ch0(16'h0000); tick();
        DIG_TH = 8'd3; set_ch0(16'h0F00); tick();
        chk("t3_valid_gt", 64'(VALID[0]), 64'd1);
        set_ch0(16'h0000); tick();

        // Double pulse with dead time
        CLR_CNT = 1'b1; tick(); CLR_CNT = 1'b0;
        DEAD_CYC = 4'd2; set_ch0(16'h0F0F); tick();
        chk("t4_valid", 64'(VALID[0]), 64'd1);
        chk("t4_tot", 64'(TOT[7:0]), 64'd4);
        chk("t4_missed", 64'(MISSED[7:0]), 64'd1);
        chk("t4_busy_a", 64'(BUSY[0]), 64'd1);
        set_ch0(16'h0FF0); tick();
        chk("t4_busy_b", 64'(BUSY[0]), 64'd1);
        set_ch0(16'h0000); tick();
        chk("t4_idle", 64'(BUSY[0]), 64'd0);
        tick();
        chk("t4_dead_ignored", 64'(VALID[0]), 64'd0);
        DEAD_CYC = 4'd0;

        // TOT and MISSED saturation, then clear
        set_ch0(16'hFFFF);
        for (int i = 0; i < 20; i++) tick();
        set_ch0(16'h0000); tick();
        chk("t5_valid", 64'(VALID[0]), 64'd1);
        chk("t5_tot_sat", 64'(TOT[7:0]), 64'd255);
        set_ch0(16'h0F0F);
        for (int i = 0; i < 300; i++) tick();
        chk("t5_missed_sat", 64'(MISSED[7:0]), 64'd255);
        set_ch0(16'h0000); CLR_CNT = 1'b1; tick(); CLR_CNT = 1'b0;
        chk("t5_missed_clr", 64'(MISSED[7:0]), 64'd0);

        // Inverted input
        EN_INVERT[0] = 1'b1; set_ch0(16'hFFFF); tick();
        TIME_STAMP = 4'd3; set_ch0(16'hF00F); tick();
        chk("t6_valid", 64'(VALID[0]), 64'd1);
        chk("t6_tot", 64'(TOT[7:0]), 64'd8);
        chk("t6_le", 64'(LE_TIME[7:0]), 64'h34);
        set_ch0(16'hFFFF); tick();
        EN_INVERT[0] = 1'b0; set_ch0(16'h0000); tick();

        // Asynchronous reset in the middle of a pulse
        set_ch0(16'h00FF); tick();
        set_ch0(16'hFFFF); tick();
        chk("t7_busy_pre", 64'(BUSY[0]), 64'd1);
        RST_N = 1'b0;
        #1;
        chk("t7_valid", 64'(VALID), 64'd0);
        chk("t7_busy", 64'(BUSY), 64'd0);
        chk("t7_tot", 64'(TOT), 64'd0);
        chk("t7_le", 64'(LE_TIME), 64'd0);
        chk("t7_missed", 64'(MISSED), 64'd0);
        model_reset();
        set_ch0(16'h0000);
        @(posedge CLK40);
        #1;
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t7_no_valid", 64'(VALID[0]), 64'd0);
        end

        // Randomized traffic on all channels
        for (int n = 0; n < 2500; n++) begin
            if (n % 64 == 0) begin
                DIG_TH   = TOT_W'($urandom_range(0, 24));
                DEAD_CYC = DEAD_W'($urandom_range(0, 3));
            end
            for (int c = 0; c < NCH; c++) begin
                last_w[c] = gen_word(last_w[c]);
                DATA[c*SAMPLES +: SAMPLES] = last_w[c];
                EN[c] = ($urandom_range(0, 99) < 95);
                if ($urandom_range(0, 199) == 0) EN_INVERT[c] = ~EN_INVERT[c];
            end
            CLR_CNT = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tlu_multi_ch_rx.md
Name: tlu_multi_ch_rx

Overview:
Multi-channel successor to the single-channel TLU input receiver. It takes NCH pre-deserialized sample words, one per channel per CLK40 cycle, from external ddr_des instances. Per channel it detects leading and trailing edges at sample resolution and measures time-over-threshold for pulses spanning any number of words. It qualifies hits against a digital threshold, applies a programmable dead time, and counts pulses it had to discard. It sits between the deserializers and the TLU trigger/coincidence logic.

Parameters:
NCH, 4, number of input channels
SAMPLES, 16, samples per channel per CLK40 cycle; power of two, >=4
POS_W, $clog2(SAMPLES), bit width of a sample position
TS_W, 4, coarse timestamp width
TOT_W, 8, TOT width in samples; saturates at 2^TOT_W-1
DEAD_W, 4, dead-time counter width

Ports:
CLK40  input  1  sole clock; all logic on posedge
RST_N  input  1  asynchronous, active-low reset
TIME_STAMP  input  TS_W  coarse time of the current word
DATA  input  NCH*SAMPLES  channel c = DATA[c*SAMPLES +: SAMPLES]; MSB is the earliest sample
EN  input  NCH  per-channel enable
EN_INVERT  input  NCH  per-channel input inversion
DIG_TH  input  TOT_W  hit qualifies if TOT > DIG_TH (strict)
DEAD_CYC  input  DEAD_W  CLK40 cycles to ignore input after a pulse ends
CLR_CNT  input  1  synchronous clear of MISSED counters
VALID  output  NCH  one-cycle pulse per qualified hit
LE_TIME  output  NCH*(TS_W+POS_W)  {TIME_STAMP, rpos} of the last reported hit
TOT  output  NCH*TOT_W  TOT of the last reported hit
BUSY  output  NCH  channel is in HIGH or DEAD
MISSED  output  NCH*8  saturating count of discarded pulses

Behaviour:
- Reset (async, RST_N=0): all outputs 0, every FSM in IDLE, previous-LSB registers 0.
- Word preparation:
  - w = EN_INVERT[c] ? ~word : word.
  - Extended word x = {prev_lsb, w}; prev_lsb is the LSB of the previous w, registered every cycle.
  - Position p counts from the MSB: p=0 is the earliest sample.
  - Rising at p: x(p)=1 and its predecessor is 0.
  - Falling at p: x(p)=0 and its predecessor is 1.
  - rpos = first rising position. fpos = first falling position at or after rpos; in HIGH, fpos = first falling position overall.
- FSM per channel: IDLE, HIGH, DEAD.
  - IDLE, rising found:
    - Falling also found in the same word: TOT = fpos-rpos; report; go to DEAD (or stay in IDLE if DEAD_CYC=0).
    - No falling: acc = SAMPLES-rpos; go to HIGH.
  - HIGH, falling found: TOT = sat(acc+fpos); report; go to DEAD or IDLE.
  - HIGH, no falling: acc = sat(acc+SAMPLES); stay in HIGH.
  - DEAD: count down DEAD_CYC cycles ignoring input, then IDLE. A pulse already high on return yields no rising edge and is not reported.
- Report (registered, 1 cycle after the word containing the trailing edge):
  - LE_TIME and TOT update unconditionally.
  - VALID[c] = 1 only if TOT > DIG_TH.
  - LE_TIME uses TIME_STAMP from the word containing the leading edge, latched at rising.
- Discarded pulses: each additional rising edge in the reporting word after fpos increments MISSED[c] once per edge, saturating at 255. CLR_CNT has priority over increment.
- Saturation: TOT never wraps. acc sticks at 2^TOT_W-1.
- EN[c]=0: FSM forced to IDLE on the next edge, measurement aborted, VALID suppressed; prev_lsb keeps tracking.
- Timestamp arithmetic: TIME_STAMP wraps modulo 2^TS_W; the block does no unwrap.
- BUSY[c] = state is HIGH or DEAD.
- Latency: VALID is 1 cycle after the trailing-edge word.
- Channels are fully independent. Simultaneous reports on all channels are allowed.

Decomposition:
- Package tlu_rx_pkg: state enum {IDLE, HIGH, DEAD}; helper sat_add function; TOT_MAX constant.
- Sub-module tlu_edge_finder (combinational, parametrised by SAMPLES): inputs x; outputs rise_found, rpos, fall_found, fpos_after_rise, fpos_first, extra_rise_cnt.
- Top instantiates NCH edge finders plus NCH per-channel FSMs in a generate loop.

Test Plan:
- Single in-word pulse, ch0 DATA=16'h0FF0, prev 0, TIME_STAMP=3, DIG_TH=5 -> next cycle VALID[0]=1, TOT=8, LE_TIME=8'h34.
- Spanning pulse over words 16'h00FF, 16'hFFFF, 16'hF000 -> TOT=8+16+4=28, VALID pulses exactly once, BUSY high for 2 cycles before the report.
- Threshold boundary: pulse with TOT=4, DIG_TH=4 -> VALID=0 but TOT=4 latched; with DIG_TH=3 -> VALID=1.
- Double pulse 16'h0F0F, DEAD_CYC=2 -> one VALID, TOT=4, MISSED=1, BUSY high 2 cycles; a rising edge during DEAD is ignored.
- Long high for 20 words -> TOT=255 (saturated); 300 double-pulse words -> MISSED=255, then CLR_CNT -> 0.
- EN_INVERT=1 with DATA=16'hF00F -> same result as 16'h0FF0. RST_N low while in HIGH -> all outputs 0 immediately, no VALID after release.
